// File: rtl/tdm_demux4.sv
`default_nettype none
// ============================================================================
// Module      : tdm_demux4
// Description : Four-channel TDM receive demultiplexer with SOF-based slot
//               tracking, per-channel strobes and a sticky framing error flag.
//               Define TDM_DEMUX_FRAME_BUF_EN to publish whole frames at ch3.
// Revision    : 1.0 - initial release
// ============================================================================
module tdm_demux4 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic [3:0]       y_valid,
    output logic             frame_done,
    output logic             locked,
    output logic             sync_err
);

    localparam logic [0:0] S_HUNT   = 1'b0;
    localparam logic [0:0] S_LOCKED = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_next_state;
    logic [1:0]       r_cnt;
    logic [1:0]       w_next_cnt;
    logic             w_accept;
    logic [1:0]       w_ch;
    logic             w_err;
    logic [WIDTH-1:0] r_y0, r_y1, r_y2, r_y3;
    logic [3:0]       r_y_valid;
    logic             r_frame_done;
    logic             r_sync_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_HUNT;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_accept     = 1'b0;
        w_ch         = 2'd0;
        w_err        = 1'b0;
        if (in_valid) begin
            case (r_state)
                S_HUNT: begin
                    if (in_sof) begin
                        w_accept     = 1'b1;
                        w_next_cnt   = 2'd1;
                        w_next_state = S_LOCKED;
                    end
                end
                default: begin
                    if (in_sof) begin
                        // An early SOF resynchronises onto the new frame.
                        w_accept   = 1'b1;
                        w_next_cnt = 2'd1;
                        w_err      = (r_cnt != 2'd0);
                    end else if (r_cnt != 2'd0) begin
                        w_accept   = 1'b1;
                        w_ch       = r_cnt;
                        w_next_cnt = r_cnt + 2'd1;
                    end else begin
                        w_err        = 1'b1;
                        w_next_state = S_HUNT;
                    end
                end
            endcase
        end
    end

    always_comb begin
        locked = (r_state == S_LOCKED);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync_err <= 1'b0;
        end else if (w_err) begin
            r_sync_err <= 1'b1;
        end
    end

`ifdef TDM_DEMUX_FRAME_BUF_EN
    logic [WIDTH-1:0] r_sh0, r_sh1, r_sh2;

    // Shadow words need no flush on a framing error: a frame only publishes
    // after ch1 and ch2 have been rewritten in sequence since its ch0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh0        <= '0;
            r_sh1        <= '0;
            r_sh2        <= '0;
            r_y0         <= '0;
            r_y1         <= '0;
            r_y2         <= '0;
            r_y3         <= '0;
            r_y_valid    <= 4'b0000;
            r_frame_done <= 1'b0;
        end else begin
            r_y_valid    <= 4'b0000;
            r_frame_done <= 1'b0;
            if (w_accept) begin
                case (w_ch)
                    2'd0: r_sh0 <= in_data;
                    2'd1: r_sh1 <= in_data;
                    2'd2: r_sh2 <= in_data;
                    default: begin
                        r_y0         <= r_sh0;
                        r_y1         <= r_sh1;
                        r_y2         <= r_sh2;
                        r_y3         <= in_data;
                        r_y_valid    <= 4'b1111;
                        r_frame_done <= 1'b1;
                    end
                endcase
            end
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y0         <= '0;
            r_y1         <= '0;
            r_y2         <= '0;
            r_y3         <= '0;
            r_y_valid    <= 4'b0000;
            r_frame_done <= 1'b0;
        end else begin
            r_y_valid    <= 4'b0000;
            r_frame_done <= 1'b0;
            if (w_accept) begin
                case (w_ch)
                    2'd0:    r_y0 <= in_data;
                    2'd1:    r_y1 <= in_data;
                    2'd2:    r_y2 <= in_data;
                    default: r_y3 <= in_data;
                endcase
                r_y_valid    <= 4'b0001 << w_ch;
                r_frame_done <= (w_ch == 2'd3);
            end
        end
    end
`endif

    assign y0         = r_y0;
    assign y1         = r_y1;
    assign y2         = r_y2;
    assign y3         = r_y3;
    assign y_valid    = r_y_valid;
    assign frame_done = r_frame_done;
    assign sync_err   = r_sync_err;

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux4.sv
`default_nettype none
// ============================================================================
// Module      : tb_tdm_demux4
// Description : Directed self-checking bench for tdm_demux4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tdm_demux4;

`ifdef TDM_DEMUX_FRAME_BUF_EN
    localparam bit BUF = 1'b1;
`else
    localparam bit BUF = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_sof;
    logic [7:0] in_data;
    logic [7:0] y0, y1, y2, y3;
    logic [3:0] y_valid;
    logic       frame_done;
    logic       locked;
    logic       sync_err;

    int n_vec;
    int n_err;
    int fd_count;

    tdm_demux4 #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_data    (in_data),
        .y0         (y0),
        .y1         (y1),
        .y2         (y2),
        .y3         (y3),
        .y_valid    (y_valid),
        .frame_done (frame_done),
        .locked     (locked),
        .sync_err   (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] exp_yv(input int k);
        if (BUF) return (k == 3) ? 4'b1111 : 4'b0000;
        return 4'b0001 << k;
    endfunction

    // Inputs change 1 time unit after a rising edge; outputs sampled there too.
    task automatic step(input logic v, input logic s, input logic [7:0] d);
        in_valid = v;
        in_sof   = s;
        in_data  = d;
        @(posedge clk);
        #1;
        if (frame_done === 1'b1) fd_count++;
    endtask

    task automatic word(input string tag, input logic s, input logic [7:0] d, input int k);
        step(1'b1, s, d);
        check({tag, "_yv"}, {28'd0, y_valid}, {28'd0, exp_yv(k)});
        check({tag, "_fd"}, {31'd0, frame_done}, {31'd0, (k == 3)});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_sof = 1'b0;
        in_data = 8'h00;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        fd_count = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        in_sof = 1'b0;
        in_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_y", {y0, y1, y2, y3}, 32'h0);
        check("rst_yv", {28'd0, y_valid}, 32'h0);
        check("rst_fd", {31'd0, frame_done}, 32'h0);
        check("rst_lock", {31'd0, locked}, 32'h0);
        check("rst_err", {31'd0, sync_err}, 32'h0);
        rst = 1'b0;

        // Continuous frame
        word("f1_w0", 1'b1, 8'hA1, 0);
        check("f1_lock", {31'd0, locked}, 32'h1);
        check("f1_y0", {24'd0, y0}, BUF ? 32'h0 : 32'hA1);
        word("f1_w1", 1'b0, 8'hB2, 1);
        word("f1_w2", 1'b0, 8'hC3, 2);
        word("f1_w3", 1'b0, 8'hD4, 3);
        check("f1_y", {y0, y1, y2, y3}, 32'hA1B2C3D4);
        check("f1_err", {31'd0, sync_err}, 32'h0);
        step(1'b0, 1'b0, 8'hEE);
        check("f1_idle_yv", {28'd0, y_valid}, 32'h0);
        check("f1_idle_fd", {31'd0, frame_done}, 32'h0);
        check("f1_hold", {y0, y1, y2, y3}, 32'hA1B2C3D4);

        // Words without SOF while hunting are dropped silently
        do_reset();
        step(1'b1, 1'b0, 8'h55);
        check("nosof_lock0", {31'd0, locked}, 32'h0);
        check("nosof_yv0", {28'd0, y_valid}, 32'h0);
        step(1'b1, 1'b0, 8'h66);
        check("nosof_lock1", {31'd0, locked}, 32'h0);
        check("nosof_y", {y0, y1, y2, y3}, 32'h0);
        check("nosof_err", {31'd0, sync_err}, 32'h0);

        // Frame with idle gaps between words
        word("gap_w0", 1'b1, 8'h10, 0);
        step(1'b0, 1'b1, 8'hFF);
        check("gap_i0", {28'd0, y_valid}, 32'h0);
        word("gap_w1", 1'b0, 8'h20, 1);
        step(1'b0, 1'b0, 8'hFF);
        check("gap_i1", {28'd0, y_valid}, 32'h0);
        word("gap_w2", 1'b0, 8'h30, 2);
        step(1'b0, 1'b0, 8'hFF);
        check("gap_i2", {28'd0, y_valid}, 32'h0);
        word("gap_w3", 1'b0, 8'h40, 3);
        check("gap_y", {y0, y1, y2, y3}, 32'h10203040);
        check("gap_err", {31'd0, sync_err}, 32'h0);

        // Early SOF resynchronises and flags an error
        fd_count = 0;
        step(1'b1, 1'b1, 8'h11);
        step(1'b1, 1'b0, 8'h22);
        check("esof_err0", {31'd0, sync_err}, 32'h0);
        step(1'b1, 1'b1, 8'h33);
        check("esof_err1", {31'd0, sync_err}, 32'h1);
        check("esof_lock", {31'd0, locked}, 32'h1);
        step(1'b1, 1'b0, 8'h44);
        step(1'b1, 1'b0, 8'h55);
        step(1'b1, 1'b0, 8'h66);
        check("esof_y", {y0, y1, y2, y3}, 32'h33445566);
        check("esof_fdcnt", fd_count, 32'd1);

        // Missing SOF after a complete frame
        do_reset();
        word("ms_w0", 1'b1, 8'h81, 0);
        word("ms_w1", 1'b0, 8'h82, 1);
        word("ms_w2", 1'b0, 8'h83, 2);
        word("ms_w3", 1'b0, 8'h84, 3);
        step(1'b1, 1'b0, 8'h77);
        check("ms_err", {31'd0, sync_err}, 32'h1);
        check("ms_lock", {31'd0, locked}, 32'h0);
        check("ms_yv", {28'd0, y_valid}, 32'h0);
        check("ms_y", {y0, y1, y2, y3}, 32'h81828384);
        word("rl_w0", 1'b1, 8'h91, 0);
        check("rl_lock", {31'd0, locked}, 32'h1);
        word("rl_w1", 1'b0, 8'h92, 1);
        word("rl_w2", 1'b0, 8'h93, 2);
        word("rl_w3", 1'b0, 8'h94, 3);
        check("rl_y", {y0, y1, y2, y3}, 32'h91929394);
        check("rl_err", {31'd0, sync_err}, 32'h1);

        // Asynchronous reset mid-frame, between clock edges
        word("mr_w0", 1'b1, 8'hA0, 0);
        word("mr_w1", 1'b0, 8'hA1, 1);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("mr_y", {y0, y1, y2, y3}, 32'h0);
        check("mr_lock", {31'd0, locked}, 32'h0);
        check("mr_err", {31'd0, sync_err}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        word("pf_w0", 1'b1, 8'h01, 0);
        check("pf_y0a", {24'd0, y0}, BUF ? 32'h0 : 32'h01);
        word("pf_w1", 1'b0, 8'h02, 1);
        check("pf_y1a", {24'd0, y1}, BUF ? 32'h0 : 32'h02);
        word("pf_w2", 1'b0, 8'h03, 2);
        word("pf_w3", 1'b0, 8'h04, 3);
        check("pf_y", {y0, y1, y2, y3}, 32'h01020304);
        step(1'b0, 1'b0, 8'h00);
        check("pf_idle_yv", {28'd0, y_valid}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tdm_demux4.md
# tdm_demux4

Four-channel time-division demultiplexer: the receive end of the 4:1 channel multiplexing path. It accepts a serial stream of words tagged with a start-of-frame marker, tracks the channel slot with a 2-bit counter, and steers each word into one of four registered channel outputs with per-channel update strobes. It sits after the serial link/deserializer and feeds the four per-channel consumers.

## Interface
- WIDTH, 8, word width of in_data and each channel output
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  in_data/in_sof qualify this cycle
- in_sof  input  1  word is channel 0 (start of frame); ignored when in_valid=0
- in_data  input  WIDTH  channel word
- y0, y1, y2, y3  output  WIDTH  registered channel outputs
- y_valid  output  4  bit k pulses one cycle when yk is updated
- frame_done  output  1  one-cycle pulse when a complete frame ends
- locked  output  1  high in LOCKED state
- sync_err  output  1  sticky framing error flag

## Operation
- States: HUNT (reset state), LOCKED. Slot counter cnt[1:0], reset 0.
- Reset (any time, incl. mid-frame): y0..y3=0, y_valid=0, frame_done=0, locked=0, sync_err=0, cnt=0, state HUNT; partial frame discarded.
- in_valid=0: no state, counter or output change; strobes deassert.
- HUNT: in_valid&in_sof -> accept as ch0, cnt=1, go LOCKED. in_valid&!in_sof -> word dropped, stay HUNT, no error.
- LOCKED, in_valid&!in_sof, cnt!=0 -> accept as ch[cnt], cnt=cnt+1 (3 wraps to 0).
- LOCKED, in_valid&in_sof, cnt==0 -> accept as ch0, cnt=1 (normal frame start).
- LOCKED, in_valid&in_sof, cnt!=0 (early SOF) -> sync_err=1, accept as ch0, cnt=1, stay LOCKED (resync).
- LOCKED, in_valid&!in_sof, cnt==0 (missing SOF) -> sync_err=1, word dropped, go HUNT.
- Accepting ch3 ends a frame: frame_done pulses.
- sync_err clears only on rst.
- Counter arithmetic is modulo 4; no other arithmetic.

## Timing
- Latency 1 cycle: word sampled at edge N appears on yk after edge N; y_valid[k] high for the cycle following edge N only.
- frame_done coincides with the ch3 update cycle.
- locked and sync_err change on the same edge as the triggering word.
- Back-to-back in_valid every cycle supported; one word per cycle max.
- Outputs hold last value between updates.

## Configuration
- TDM_DEMUX_FRAME_BUF_EN defined: ch0..ch2 words are written to shadow registers; yk do not change on those words, y_valid stays 0. On the edge accepting ch3, all four yk load together (y3 from in_data), y_valid=4'b1111 and frame_done pulse for one cycle. Early SOF or missing SOF discards the shadow frame; outputs keep the previous complete frame.
- Undefined: per-word update as above, y_valid one-hot.

## Test plan
- Reset then frame A1,B2,C3,D4 (SOF on A1), in_valid continuous -> y0..y3=A1,B2,C3,D4; y_valid 0001,0010,0100,1000 on successive cycles; frame_done with ch3; locked=1; sync_err=0.
- Words 55,66 without SOF after reset -> dropped, locked=0, outputs 0, sync_err=0.
- Frame with in_valid gaps (valid every other cycle) 10,20,30,40 -> same outputs as continuous, strobes only after valid words.
- Early SOF: SOF 11,22, then SOF 33,44,55,66 -> sync_err=1, y0=33,y1=44,y2=55,y3=66, frame_done once.
- Missing SOF after full frame: next word 77 without SOF -> sync_err=1, locked=0, 77 not written; then SOF frame relocks.
- rst asserted mid-frame (after ch1) -> all outputs 0 immediately; with TDM_DEMUX_FRAME_BUF_EN, a full frame 01,02,03,04 -> y updates only at ch3, y_valid=1111 one cycle.
